// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the control unit it feeds:
// instruction field positions, branch-select encodings, reset PC and fetch states.
package cpu_pkg;

    // Instruction field positions
    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned JTGT_MSB  = 25;
    localparam int unsigned IMM_MSB   = 15;

    // Branch-select encodings from the control unit (3 behaves as none)
    localparam logic [1:0] BR_NONE   = 2'd0;
    localparam logic [1:0] BR_COND   = 2'd1;
    localparam logic [1:0] BR_UNCOND = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_VALID,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: halt > return > jump > branch > sequential.
// Also computes the jump/branch targets and flags/aligns misaligned targets.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]   i_pc_plus4,
    input  logic [JTGT_MSB:0]   i_instr_lo,
    input  logic                i_jump,
    input  logic [1:0]          i_branch,
    input  logic                i_branch_taken,
    input  logic                i_ret_pc,
    input  logic                i_halt_pc,
    input  logic [ADDR_W-1:0]   i_ret_addr,
    output logic                o_halt,
    output logic [ADDR_W-1:0]   o_next_pc,
    output logic                o_misalign
);

    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_raw;
    logic              w_br_take;

    assign w_jump_tgt = {i_pc_plus4[ADDR_W-1:28], i_instr_lo, 2'b00};
    assign w_br_tgt   = i_pc_plus4 +
                        {{(ADDR_W-18){i_instr_lo[IMM_MSB]}}, i_instr_lo[IMM_MSB:0], 2'b00};

    // Decode whether the branch field requests a taken branch
    always_comb begin
        w_br_take = 1'b0;
        case (i_branch)
            BR_NONE:   w_br_take = 1'b0;
            BR_COND:   w_br_take = i_branch_taken;
            BR_UNCOND: w_br_take = 1'b1;
            default:   w_br_take = 1'b0;
        endcase
    end

    // Priority selection of the raw (possibly misaligned) target
    always_comb begin
        w_raw = i_pc_plus4;
        if (i_halt_pc)
            w_raw = i_pc_plus4;
        else if (i_ret_pc)
            w_raw = i_ret_addr;
        else if (i_jump)
            w_raw = w_jump_tgt;
        else if (w_br_take)
            w_raw = w_br_tgt;
        else
            w_raw = i_pc_plus4;
    end

    assign o_halt     = i_halt_pc;
    assign o_misalign = |w_raw[1:0];
    assign o_next_pc  = {w_raw[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory,
// holds the fetched word in IR and advances the PC on pc_update rising edges.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_update,
    input  logic               jump,
    input  logic [1:0]         branch,
    input  logic               branch_taken,
    input  logic               ret_pc,
    input  logic               halt_pc,
    input  logic [ADDR_W-1:0]  ret_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid,
    output logic               halted,
    output logic               misalign_err
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_pc_update_d;
    logic               r_misalign_err;

    logic               w_pc_edge;
    logic               w_advance;
    logic               w_halt_sel;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic               w_misalign;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_pc_edge  = pc_update & ~r_pc_update_d;
    assign w_advance  = (r_state == ST_VALID) && w_pc_edge;

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .i_pc_plus4     (w_pc_plus4),
        .i_instr_lo     (r_instr[JTGT_MSB:0]),
        .i_jump         (jump),
        .i_branch       (branch),
        .i_branch_taken (branch_taken),
        .i_ret_pc       (ret_pc),
        .i_halt_pc      (halt_pc),
        .i_ret_addr     (ret_addr),
        .o_halt         (w_halt_sel),
        .o_next_pc      (w_next_pc),
        .o_misalign     (w_misalign)
    );

    // Fetch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; pc_update edges outside VALID fall through unused
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_REQ;
            ST_REQ:   if (imem_ack) w_state_nxt = ST_VALID;
            ST_VALID: if (w_pc_edge) w_state_nxt = w_halt_sel ? ST_HALT : ST_REQ;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; the request drops with the state change on ack
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            ST_REQ:   imem_req    = 1'b1;
            ST_VALID: instr_valid = 1'b1;
            ST_HALT:  halted      = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers: edge detector, IR capture, PC load, sticky misalign flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_update_d  <= 1'b0;
            r_instr        <= '0;
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
        end else begin
            r_pc_update_d <= pc_update;
            if ((r_state == ST_REQ) && imem_ack)
                r_instr <= imem_rdata;
            if (w_advance && !w_halt_sel) begin
                r_pc <= w_next_pc;
                if (w_misalign)
                    r_misalign_err <= 1'b1;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign instr        = r_instr;
    assign opcode       = r_instr[OPC_MSB:OPC_LSB];
    assign funct        = r_instr[FUNCT_MSB:FUNCT_LSB];
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized fetch/advance sequence checked against a next-PC reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_update, jump, branch_taken, ret_pc, halt_pc;
    logic [1:0]  branch;
    logic [31:0] ret_addr;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic        instr_valid, halted, misalign_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_update    (pc_update),
        .jump         (jump),
        .branch       (branch),
        .branch_taken (branch_taken),
        .ret_pc       (ret_pc),
        .halt_pc      (halt_pc),
        .ret_addr     (ret_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference next-PC: raw target from the selection rules (caller aligns)
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                               input logic j, input logic [1:0] br, input logic bt,
                                               input logic r, input logic [31:0] ra);
        logic [31:0] seq;
        logic [15:0] imm;
        seq = p + 32'd4;
        imm = ir[15:0];
        if (r) return ra;
        if (j) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
        if (br == 2'd2 || (br == 2'd1 && bt)) return seq + 32'($signed(imm) * 4);
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        pc_update = 0; jump = 0; branch = 0; branch_taken = 0;
        ret_pc = 0; halt_pc = 0; ret_addr = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0; imem_ack = 0; imem_rdata = 0;
        clear_ctrl();
        repeat (2) tick();
        rst_n = 1;
    endtask

    // Waits (bounded) for a request, stalls 'delay' cycles, then acks one cycle
    task automatic serve_fetch(input logic [31:0] data, input int unsigned delay, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (imem_req === 1'b1) ok = 1;
            else tick();
        end
        if (!ok) return;
        repeat (delay) tick();
        imem_ack = 1; imem_rdata = data;
        tick();
        imem_ack = 0; imem_rdata = $urandom;
    endtask

    // Holds pc_update for two cycles with the given controls, then clears them
    task automatic pulse_update(input logic j, input logic [1:0] br, input logic bt,
                                input logic r, input logic h, input logic [31:0] ra);
        jump = j; branch = br; branch_taken = bt; ret_pc = r; halt_pc = h; ret_addr = ra;
        pc_update = 1;
        tick(); tick();
        clear_ctrl();
    endtask

    task automatic test_reset();
        rst_n = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        clear_ctrl();
        repeat (2) tick();
        n_tests++; if (pc !== 32'h0 || instr !== 32'h0) begin n_fail++;
            $display("FAIL reset_regs: pc=%h instr=%h, want 0/0", pc, instr); end
        n_tests++; if ({imem_req, instr_valid, halted, misalign_err} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: req/valid/halted/mis=%b, want 0000",
                     {imem_req, instr_valid, halted, misalign_err}); end
        rst_n = 1;
        tick();
        imem_ack = 0;
        n_tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin n_fail++;
            $display("FAIL reset_ack_ignored: valid=%b instr=%h req=%b, want 0/0/1",
                     instr_valid, instr, imem_req); end
    endtask

    task automatic test_first_fetch();
        bit ok;
        apply_reset();
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL first_req: req=%b addr=%h, want 1/0", imem_req, imem_addr); end
        serve_fetch(32'h0022_1820, 0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL first_serve: no request seen"); end
        n_tests++; if (instr_valid !== 1 || opcode !== 6'h0 || funct !== 6'h20 || pc !== 32'h0) begin
            n_fail++; $display("FAIL first_fetch: valid=%b op=%h fn=%h pc=%h, want 1/00/20/0",
                               instr_valid, opcode, funct, pc); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++;
            $display("FAIL first_req_drop: req=%b, want 0", imem_req); end
    endtask

    task automatic test_hold_update();
        bit ok;
        pulse_update(0, 0, 0, 0, 0, 0);
        n_tests++; if (pc !== 32'h4 || pc_plus4 !== 32'h8) begin n_fail++;
            $display("FAIL single_advance: pc=%h pc_plus4=%h, want 4/8", pc, pc_plus4); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++;
                $display("FAIL req_stable[%0d]: req=%b addr=%h, want 1/4", i, imem_req, imem_addr); end
            tick();
        end
        imem_ack = 1; imem_rdata = 32'h0000_0000; tick(); imem_ack = 0;
        n_tests++; if (instr_valid !== 1'b1 || pc !== 32'h4) begin n_fail++;
            $display("FAIL delayed_ack: valid=%b pc=%h, want 1/4", instr_valid, pc); end
        ok = 1;
    endtask

    task automatic test_branch();
        bit ok;
        pulse_update(0, 0, 0, 0, 0, 0);
        serve_fetch(32'h3C00_FFFE, 1, ok);
        n_tests++; if (!ok || pc !== 32'h8 || instr !== 32'h3C00_FFFE) begin n_fail++;
            $display("FAIL br_setup: ok=%b pc=%h instr=%h, want 1/8/3c00fffe", ok, pc, instr); end
        pulse_update(0, 2'd1, 1, 0, 0, 0);
        n_tests++; if (pc !== 32'h4) begin n_fail++;
            $display("FAIL branch_taken: pc=%h, want 4", pc); end
        serve_fetch(32'h0000_0000, 0, ok);
        pulse_update(0, 0, 0, 0, 0, 0);
        serve_fetch(32'h3C00_FFFE, 0, ok);
        pulse_update(0, 2'd1, 0, 0, 0, 0);
        n_tests++; if (!ok || pc !== 32'hC) begin n_fail++;
            $display("FAIL branch_not_taken: pc=%h, want c", pc); end
        serve_fetch(32'h3C00_FFFE, 0, ok);
        pulse_update(0, 2'd3, 1, 0, 0, 0);
        n_tests++; if (pc !== 32'h10) begin n_fail++;
            $display("FAIL branch_code3: pc=%h, want 10", pc); end
    endtask

    task automatic test_jump_ret();
        bit ok;
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 1, 0, 32'h1000_0000);
        serve_fetch(32'h0800_0040, 2, ok);
        n_tests++; if (!ok || pc !== 32'h1000_0000) begin n_fail++;
            $display("FAIL ret_load: pc=%h, want 10000000", pc); end
        pulse_update(1, 2'd2, 0, 0, 0, 0);
        n_tests++; if (pc !== 32'h1000_0100) begin n_fail++;
            $display("FAIL jump: pc=%h, want 10000100", pc); end
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 1, 0, 32'h1000_0000);
        serve_fetch(32'h0800_0040, 0, ok);
        pulse_update(1, 0, 0, 1, 0, 32'h20);
        n_tests++; if (pc !== 32'h20 || misalign_err !== 1'b0) begin n_fail++;
            $display("FAIL ret_over_jump: pc=%h mis=%b, want 20/0", pc, misalign_err); end
    endtask

    task automatic test_misalign_halt();
        bit ok;
        logic [31:0] held;
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 1, 0, 32'h22);
        n_tests++; if (misalign_err !== 1'b1 || imem_addr !== 32'h20) begin n_fail++;
            $display("FAIL misalign: mis=%b addr=%h, want 1/20", misalign_err, imem_addr); end
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 0, 0, 0);
        n_tests++; if (misalign_err !== 1'b1 || pc !== 32'h24) begin n_fail++;
            $display("FAIL misalign_sticky: mis=%b pc=%h, want 1/24", misalign_err, pc); end
        serve_fetch(32'h0, 0, ok);
        held = pc;
        pulse_update(1, 0, 0, 1, 1, 32'h100);
        n_tests++; if (halted !== 1 || instr_valid !== 0 || imem_req !== 0 || pc !== held) begin
            n_fail++; $display("FAIL halt: halted=%b valid=%b req=%b pc=%h, want 1/0/0/%h",
                               halted, instr_valid, imem_req, pc, held); end
        tick();
        pulse_update(0, 0, 0, 1, 0, 32'h40);
        imem_ack = 1; tick(); tick(); imem_ack = 0;
        n_tests++; if (halted !== 1 || imem_req !== 0 || pc !== held || instr_valid !== 0) begin
            n_fail++; $display("FAIL halt_sticky: halted=%b req=%b pc=%h valid=%b, want 1/0/%h/0",
                               halted, imem_req, pc, instr_valid, held); end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 0, 0, 0);
        n_tests++; if (pc !== 32'h0 || misalign_err !== 1'b0) begin n_fail++;
            $display("FAIL wrap: pc=%h mis=%b, want 0/0", pc, misalign_err); end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        serve_fetch(32'h0, 0, ok);
        pulse_update(0, 0, 0, 1, 0, 32'h0000_0400);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++;
            $display("FAIL mid_setup: req=%b addr=%h, want 1/400", imem_req, imem_addr); end
        #2 rst_n = 0;
        #1;
        n_tests++; if (imem_req !== 1'b0 || pc !== 32'h0) begin n_fail++;
            $display("FAIL async_reset: req=%b pc=%h, want 0/0", imem_req, pc); end
        imem_ack = 1;
        tick();
        imem_ack = 0;
        rst_n = 1;
        serve_fetch(32'hABCD_1234, 0, ok);
        n_tests++; if (!ok || pc !== 32'h0 || instr !== 32'hABCD_1234) begin n_fail++;
            $display("FAIL restart: ok=%b pc=%h instr=%h, want 1/0/abcd1234", ok, pc, instr); end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] m_pc, m_ir, tgt, ra;
        logic        m_mis, j, bt, r;
        logic [1:0]  br;
        apply_reset();
        m_pc = 32'h0; m_mis = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                pc_update = 1; tick(); pc_update = 0;
            end
            m_ir = $urandom;
            serve_fetch(m_ir, $urandom_range(0, 3), ok);
            n_tests++; if (!ok || pc !== m_pc || instr !== m_ir || opcode !== m_ir[31:26] ||
                           funct !== m_ir[5:0] || instr_valid !== 1'b1) begin
                n_fail++; $display("FAIL rand_fetch[%0d]: pc=%h instr=%h valid=%b, want %h/%h/1",
                                   it, pc, instr, instr_valid, m_pc, m_ir); end
            j = ($urandom_range(0, 3) == 0); br = 2'($urandom);
            bt = 1'($urandom); r = ($urandom_range(0, 4) == 0); ra = $urandom;
            tgt = model_next(m_pc, m_ir, j, br, bt, r, ra);
            if (tgt[1:0] != 2'b00) m_mis = 1;
            m_pc = tgt & 32'hFFFF_FFFC;
            pulse_update(j, br, bt, r, 0, ra);
            n_tests++; if (pc !== m_pc || misalign_err !== m_mis || imem_req !== 1'b1) begin
                n_fail++; $display("FAIL rand_next[%0d]: pc=%h mis=%b req=%b, want %h/%b/1",
                                   it, pc, misalign_err, imem_req, m_pc, m_mis); end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_update();
        test_branch();
        test_jump_ret();
        test_misalign_halt();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the multi-cycle control unit.
- Owns the PC and issues a req/ack read to instruction memory.
- Latches the returned word into the instruction register (IR) and presents opcode/funct to the control unit.
- On each PC-update pulse from the control unit, selects the next PC from the sequential, branch, jump and return sources, or halts.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_update  in  1  from control unit; only its rising edge advances the PC
jump  in  1  from control unit; select jump target
branch  in  2  0 none, 1 conditional (uses branch_taken), 2 unconditional, 3 treated as none
branch_taken  in  1  ALU condition result, sampled on the pc_update edge
ret_pc  in  1  select ret_addr as next PC
halt_pc  in  1  stop fetching
ret_addr  in  ADDR_W  return address from the datapath
imem_req  out  1  instruction read request
imem_addr  out  ADDR_W  read address (equals pc)
imem_ack  in  1  read data valid this cycle
imem_rdata  in  INSTR_W  instruction word
instr  out  INSTR_W  IR contents
opcode  out  6  instr[31:26]
funct  out  6  instr[5:0]
pc  out  ADDR_W  address of the instruction currently in IR
pc_plus4  out  ADDR_W  pc + 4
instr_valid  out  1  IR holds a fetched, unconsumed instruction
halted  out  1  fetch stopped
misalign_err  out  1  sticky: a target had bits [1:0] != 0

Behaviour:
- Reset (async, any state, mid-fetch included) sets:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, misalign_err=0, state=IDLE.
  - Any imem_ack arriving while rst_n is low, or in the first cycle after release, is ignored.
- States: IDLE, REQ, VALID, HALT.
- IDLE: one cycle, then REQ.
- REQ:
  - imem_req=1 with imem_addr=pc, both held stable until imem_ack.
  - imem_ack may arrive in the first REQ cycle (1-cycle latency minimum); there is no timeout.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to VALID.
- VALID:
  - IR is stable; opcode/funct are combinational slices of instr.
  - Wait for a pc_update rising edge (registered pc_update_d; edge = pc_update & ~pc_update_d).
  - A level held for multiple cycles counts once; the control unit holds it for two cycles.
- Next-PC selection on the edge, in priority order:
  1. halt_pc: pc unchanged, go to HALT.
  2. ret_pc: ret_addr.
  3. jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  4. branch==2, or branch==1 & branch_taken: pc_plus4 + (sign-extended instr[15:0] << 2).
  5. Otherwise: pc_plus4.
- Non-halt outcomes load pc, clear instr_valid and go to REQ the following cycle; fetch starts one cycle after the edge.
- Misaligned target:
  - If the selected target has bits [1:0] != 0: set misalign_err (sticky until reset), force bits [1:0] to 00, continue fetching.
- Address arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- pc_update edges outside VALID (IDLE, REQ, HALT) are ignored and are not queued.
- HALT: halted=1, instr_valid=0, imem_req=0; leave only by reset.
- Simultaneous jump and branch: jump wins. Simultaneous ret_pc and jump: ret wins.

Decomposition:
- Shared package (cpu_pkg): opcode/funct field positions, BR_NONE/BR_COND/BR_UNCOND encodings, RESET_PC default, fetch state encoding.
- One sub-module, next_pc_sel: combinational priority mux plus the branch/jump target adders; the FSM and registers stay in the top module.

Test Plan:
- Reset release; ack 1 cycle after req with rdata=32'h0022_1820 -> imem_addr=0, instr_valid=1, opcode=0, funct=6'h20, pc=0.
- pc_update high for 2 cycles, no branch/jump -> exactly one advance; next imem_addr=4; ack delayed 5 cycles -> imem_req and imem_addr held stable throughout.
- pc=8, instr=32'h3C00_FFFE, branch=1, branch_taken=1 -> next pc = 12 + (-2<<2) = 4; with branch_taken=0 -> 12.
- pc=32'h1000_0000, jump=1, instr[25:0]=26'h40 -> next pc=32'h1000_0100; same cycle with ret_pc=1, ret_addr=32'h20 -> pc=32'h20.
- ret_addr=32'h22 -> misalign_err=1, imem_addr=32'h20; halt_pc=1 on the next edge -> halted=1, further pc_update edges and acks are ignored.
- rst_n low while in REQ with ack pending -> imem_req=0 immediately; after release, fetch restarts at RESET_PC.
